// File: rtl/store_buffer_dmem_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_dmem_pkg
// Shared defaults and the store-buffer entry type used by store_buffer_dmem
// and its FIFO sub-module sb_fifo.
//
// The entry struct is sized for the largest supported configuration
// (data up to SB_DATA_MAX_W bits, word index up to SB_IDX_MAX_W bits).
// Narrower instances zero-extend into it and use only the low bits.
// -----------------------------------------------------------------------------
package store_buffer_dmem_pkg;

    localparam int SB_DEPTH_DEFAULT     = 4;
    localparam int SB_MEM_WORDS_DEFAULT = 64;
    localparam int SB_DATA_MAX_W        = 64;
    localparam int SB_IDX_MAX_W         = 16;

    typedef struct packed {
        logic [SB_IDX_MAX_W-1:0]  idx;   // data-memory word index
        logic [SB_DATA_MAX_W-1:0] data;  // store data
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
// Circular store-buffer FIFO with an associative lookup port that returns the
// youngest entry whose word index matches lookup_idx.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset (clears pointers/count)
//   push        in   append push_entry at tail
//   push_entry  in   entry to append
//   pop         in   remove head entry (caller guarantees count > 0)
//   head        out  oldest entry
//   count       out  number of valid entries, 0..DEPTH
//   lookup_idx  in   word index to search for
//   hit         out  some valid entry matches lookup_idx
//   hit_entry   out  youngest matching entry (zero when no hit)
// -----------------------------------------------------------------------------
module sb_fifo
    import store_buffer_dmem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  sb_entry_t               push_entry,
    input  logic                    pop,
    output sb_entry_t               head,
    output logic [CNT_W-1:0]        count,
    input  logic [SB_IDX_MAX_W-1:0] lookup_idx,
    output logic                    hit,
    output sb_entry_t               hit_entry
);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is defined by head/count.
    always_ff @(posedge clk) begin
        if (push) entries[tail_ptr] <= push_entry;
    end

    assign head = entries[head_ptr];

    // Walk entries oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [PTR_W-1:0] slot;
        hit       = 1'b0;
        hit_entry = '0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[slot].idx == lookup_idx)) begin
                hit       = 1'b1;
                hit_entry = entries[slot];
            end
        end
    end

endmodule

// File: rtl/store_buffer_dmem.sv
// -----------------------------------------------------------------------------
// store_buffer_dmem
// Data memory fronted by a small store buffer. Stores are queued and drained
// to the RAM on cycles where no load uses the RAM port; loads complete in the
// same cycle, forwarding from the youngest matching buffered store.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset (discards pending stores)
//   DM_addr         in   byte address (must be 8-byte aligned)
//   DM_writeData    in   store data
//   DM_writeEnable  in   store request
//   DM_readEnable   in   load request
//   DM_readData     out  load data, combinational; 0 when no aligned load
//   stall           out  store not accepted this cycle
//   misalign        out  DM_addr[2:0] nonzero while a request is asserted
//   sb_empty        out  no pending stores
// -----------------------------------------------------------------------------
module store_buffer_dmem
    import store_buffer_dmem_pkg::*;
#(
    parameter int N         = 64,
    parameter int DEPTH     = SB_DEPTH_DEFAULT,
    parameter int MEM_WORDS = SB_MEM_WORDS_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         stall,
    output logic         misalign,
    output logic         sb_empty
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [N-1:0]     mem [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             store_ok;
    logic             load_ok;
    logic             full;
    logic             drain;
    logic             push;
    sb_entry_t        push_entry;
    sb_entry_t        head;
    sb_entry_t        hit_entry;
    logic             hit;
    logic [CNT_W-1:0] count;
    logic             unused_bits;

    // Upper address bits are dropped, so addresses wrap modulo MEM_WORDS*8.
    assign word_idx = DM_addr[IDX_W+2:3];

    assign misalign = (DM_writeEnable | DM_readEnable) & (DM_addr[2:0] != 3'b000);
    assign store_ok = DM_writeEnable & ~misalign;
    assign load_ok  = DM_readEnable & ~misalign;

    assign full     = (count == CNT_W'(DEPTH));
    assign sb_empty = (count == '0);

    // A load owns the RAM port, so the buffer drains only on load-free cycles.
    assign drain = ~sb_empty & ~DM_readEnable;

    // When full and no load is present the head drains on the same edge,
    // which frees the slot the new store needs.
    assign stall = store_ok & full & DM_readEnable;
    assign push  = store_ok & ~stall;

    always_comb begin
        push_entry      = '0;
        push_entry.idx  = SB_IDX_MAX_W'(word_idx);
        push_entry.data = SB_DATA_MAX_W'(DM_writeData);
    end

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head       (head),
        .count      (count),
        .lookup_idx (SB_IDX_MAX_W'(word_idx)),
        .hit        (hit),
        .hit_entry  (hit_entry)
    );

    // Memory is deliberately not reset; words drained before a reset persist.
    always_ff @(posedge clk) begin
        if (drain) mem[head.idx[IDX_W-1:0]] <= head.data[N-1:0];
    end

    // Zero-latency load. A store in the same cycle has not been pushed yet,
    // so the load naturally observes pre-store data.
    always_comb begin
        DM_readData = '0;
        if (load_ok) begin
            DM_readData = hit ? hit_entry.data[N-1:0] : mem[word_idx];
        end
    end

    assign unused_bits = ^{DM_addr, head, hit_entry};

endmodule

// File: tb/tb_store_buffer_dmem.sv
module tb_store_buffer_dmem;
    import store_buffer_dmem_pkg::*;

    localparam int N         = 64;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic         DM_readEnable;
    logic [N-1:0] DM_readData;
    logic         stall;
    logic         misalign;
    logic         sb_empty;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    store_buffer_dmem #(
        .N         (N),
        .DEPTH     (DEPTH),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readEnable  (DM_readEnable),
        .DM_readData    (DM_readData),
        .stall          (stall),
        .misalign       (misalign),
        .sb_empty       (sb_empty)
    );

    // Reference model: a queue of pending stores plus a word-addressed memory
    // with a "known" flag per word (the RAM is never initialised).
    typedef struct {
        int           idx;
        logic [N-1:0] data;
    } ent_t;

    ent_t         sbq [$];
    logic [N-1:0] mem_m [MEM_WORDS];
    bit           mem_v [MEM_WORDS];

    function automatic int widx(input logic [N-1:0] a);
        return (int'(a) / 8) % MEM_WORDS;
    endfunction

    function automatic bit req_mis();
        return (DM_writeEnable || DM_readEnable) && (DM_addr % 8 != 0);
    endfunction

    function automatic bit exp_stall();
        return DM_writeEnable && !req_mis() && (sbq.size() == DEPTH) && DM_readEnable;
    endfunction

    function automatic bit model_load(input logic [N-1:0] a, output logic [N-1:0] v);
        int w;
        w = widx(a);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].idx == w) begin
                v = sbq[i].data;
                return 1'b1;
            end
        end
        v = mem_m[w];
        return mem_v[w];
    endfunction

    task automatic set_in(input logic we, input logic re, input logic [N-1:0] a,
                          input logic [N-1:0] d);
        DM_writeEnable = we;
        DM_readEnable  = re;
        DM_addr        = a;
        DM_writeData   = d;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit           st, mis, we, re;
        logic [N-1:0] a, d;
        st  = exp_stall();
        mis = req_mis();
        we  = DM_writeEnable;
        re  = DM_readEnable;
        a   = DM_addr;
        d   = DM_writeData;
        @(posedge clk);
        if (!re && sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_m[e.idx] = e.data;
            mem_v[e.idx] = 1'b1;
        end
        if (we && !mis && !st) sbq.push_back('{idx: widx(a), data: d});
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb_empty !== 1'b1) $display("FAIL reset_empty_held: got %b want 1", sb_empty);
        else passed++;
        total++;
        if (stall !== 1'b0) $display("FAIL reset_stall_held: got %b want 0", stall);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign);
        else passed++;
        set_in(0, 1, 64'h13, '0);
        #1;
        total++;
        if (misalign !== 1'b1 || DM_readData !== '0)
            $display("FAIL reset_mis_load: got mis=%b rd=%0h want mis=1 rd=0", misalign, DM_readData);
        else passed++;
        set_in(0, 0, '0, '0);
        tick();
        total++;
        if (sb_empty !== 1'b1) $display("FAIL reset_empty_after: got %b want 1", sb_empty);
        else passed++;
    endtask

    task automatic test_forward();
        set_in(1, 0, 64'h10, 64'hAA);
        #1;
        total++;
        if (sb_empty !== 1'b1) $display("FAIL fwd_empty_before: got %b want 1", sb_empty);
        else passed++;
        tick();
        set_in(0, 1, 64'h10, '0);
        #1;
        total++;
        if (DM_readData !== 64'hAA) $display("FAIL fwd_data: got %0h want aa", DM_readData);
        else passed++;
        total++;
        if (sb_empty !== 1'b0) $display("FAIL fwd_not_empty: got %b want 0", sb_empty);
        else passed++;
        tick();
        set_in(0, 0, '0, '0);
        tick();
        total++;
        if (sb_empty !== 1'b1) $display("FAIL fwd_drained: got %b want 1", sb_empty);
        else passed++;
        set_in(0, 1, 64'h10, '0);
        #1;
        total++;
        if (DM_readData !== 64'hAA) $display("FAIL fwd_mem_data: got %0h want aa", DM_readData);
        else passed++;
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, N'(i * 8), N'(64'h100 + i));
            #1;
            total++;
            if (stall !== 1'b0) $display("FAIL full_fill_stall%0d: got %b want 0", i, stall);
            else passed++;
            tick();
        end
        set_in(1, 1, 64'h20, 64'h555);
        #1;
        total++;
        if (stall !== 1'b1) $display("FAIL full_stall: got %b want 1", stall);
        else passed++;
        tick();
        set_in(1, 0, 64'h20, 64'h555);
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL full_no_load_stall: got %b want 0", stall);
        else passed++;
        tick();
        set_in(0, 1, 64'h0, '0);
        #1;
        total++;
        if (DM_readData !== 64'h100) $display("FAIL full_drained_head: got %0h want 100", DM_readData);
        else passed++;
        set_in(0, 1, 64'h20, '0);
        #1;
        total++;
        if (DM_readData !== 64'h555) $display("FAIL full_pushed_tail: got %0h want 555", DM_readData);
        else passed++;
        set_in(0, 0, '0, '0);
        repeat (3) tick();
        total++;
        if (sb_empty !== 1'b0) $display("FAIL full_count4_after3: got %b want 0", sb_empty);
        else passed++;
        tick();
        total++;
        if (sb_empty !== 1'b1) $display("FAIL full_count4_after4: got %b want 1", sb_empty);
        else passed++;
    endtask

    task automatic test_same_word();
        set_in(1, 0, 64'h20, 64'h1);
        tick();
        set_in(1, 0, 64'h20, 64'h2);
        tick();
        set_in(0, 0, '0, '0);
        repeat (3) tick();
        total++;
        if (sb_empty !== 1'b1) $display("FAIL same_word_empty: got %b want 1", sb_empty);
        else passed++;
        set_in(0, 1, 64'h20, '0);
        #1;
        total++;
        if (DM_readData !== 64'h2) $display("FAIL same_word_order: got %0h want 2", DM_readData);
        else passed++;
        tick();
    endtask

    task automatic test_misalign();
        logic [N-1:0] ev;
        bit           known;
        set_in(1, 0, 64'h13, 64'hDEAD);
        #1;
        total++;
        if (misalign !== 1'b1 || stall !== 1'b0)
            $display("FAIL mis_store: got mis=%b stall=%b want mis=1 stall=0", misalign, stall);
        else passed++;
        tick();
        total++;
        if (sb_empty !== 1'b1) $display("FAIL mis_no_push: got %b want 1", sb_empty);
        else passed++;
        set_in(0, 1, 64'h10, '0);
        #1;
        known = model_load(64'h10, ev);
        total++;
        if (!known || misalign !== 1'b0 || DM_readData !== ev)
            $display("FAIL mis_word_intact: got mis=%b rd=%0h want mis=0 rd=%0h", misalign, DM_readData, ev);
        else passed++;
        set_in(0, 0, '0, '0);
        tick();
    endtask

    task automatic test_reset_mid();
        set_in(1, 0, 64'h30, 64'h1111);
        tick();
        set_in(1, 0, 64'h38, 64'h2222);
        tick();
        set_in(1, 1, 64'h30, 64'h3333);
        tick();
        set_in(0, 0, '0, '0);
        #2;
        total++;
        if (sb_empty !== 1'b0) $display("FAIL rmid_pending: got %b want 0", sb_empty);
        else passed++;
        reset = 1'b1;
        #1;
        sbq.delete();
        total++;
        if (sb_empty !== 1'b1 || stall !== 1'b0)
            $display("FAIL rmid_async_clear: got empty=%b stall=%b want 1/0", sb_empty, stall);
        else passed++;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        set_in(0, 1, 64'h30, '0);
        #1;
        total++;
        if (DM_readData !== 64'h1111) $display("FAIL rmid_drained_word: got %0h want 1111", DM_readData);
        else passed++;
        set_in(0, 1, 64'h38, '0);
        #1;
        total++;
        if (DM_readData === 64'h2222) $display("FAIL rmid_discarded: got %0h want not 2222", DM_readData);
        else passed++;
        set_in(0, 0, '0, '0);
        tick();
        total++;
        if (sb_empty !== 1'b1) $display("FAIL rmid_stays_empty: got %b want 1", sb_empty);
        else passed++;
    endtask

    task automatic test_wrap();
        set_in(1, 0, 64'h200, 64'hC0FFEE);
        #1;
        total++;
        if (misalign !== 1'b0) $display("FAIL wrap_misalign: got %b want 0", misalign);
        else passed++;
        tick();
        set_in(0, 0, '0, '0);
        tick();
        set_in(0, 1, 64'h0, '0);
        #1;
        total++;
        if (DM_readData !== 64'hC0FFEE) $display("FAIL wrap_word0: got %0h want c0ffee", DM_readData);
        else passed++;
        set_in(0, 1, 64'h1000, '0);
        #1;
        total++;
        if (DM_readData !== 64'hC0FFEE) $display("FAIL wrap_alias: got %0h want c0ffee", DM_readData);
        else passed++;
        set_in(0, 0, '0, '0);
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic         we, re;
            logic [N-1:0] a, d, ev;
            bit           known;
            we = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 2) == 0);
            a  = (N'($urandom_range(0, 7)) << 3) | (N'($urandom_range(0, 3)) << 9);
            if ($urandom_range(0, 9) == 0) a = a | N'($urandom_range(1, 7));
            d  = {$urandom, $urandom};
            set_in(we, re, a, d);
            #1;
            total++;
            if (misalign !== req_mis()) $display("FAIL rnd_misalign[%0d]: got %b want %b", k, misalign, req_mis());
            else passed++;
            total++;
            if (stall !== exp_stall()) $display("FAIL rnd_stall[%0d]: got %b want %b", k, stall, exp_stall());
            else passed++;
            total++;
            if (sb_empty !== (sbq.size() == 0))
                $display("FAIL rnd_empty[%0d]: got %b want %b", k, sb_empty, sbq.size() == 0);
            else passed++;
            if (req_mis()) begin
                total++;
                if (DM_readData !== '0) $display("FAIL rnd_mis_data[%0d]: got %0h want 0", k, DM_readData);
                else passed++;
            end else if (re) begin
                known = model_load(a, ev);
                if (known) begin
                    total++;
                    if (DM_readData !== ev) $display("FAIL rnd_load[%0d]: got %0h want %0h", k, DM_readData, ev);
                    else passed++;
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_v[i] = 1'b0;
            mem_m[i] = '0;
        end
        test_reset();
        test_forward();
        test_full();
        test_same_word();
        test_misalign();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
